// File: rtl/controle_mult.sv
// controle_mult: sequencing controller for a shift-add multiplier accumulator.
// It issues one Load, then one Ad/Sh or Sh step per multiplier bit, then holds
// Done until the start request is released. The strobes are decoded
// combinationally from the state, K, St and M.
module controle_mult #(
  parameter int N = 4
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic St,
  input  logic M,
  output logic Load,
  output logic Ad,
  output logic Sh,
  output logic Busy,
  output logic Done
);

  localparam int KW = $clog2(N);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHECK = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t        r_state;
  logic [KW-1:0] r_k;
  logic          w_last;

  assign w_last = (r_k == K_LAST);

  // State and iteration counter; reset returns to IDLE without waiting for a clock.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= IDLE;
      r_k     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (St) begin
            r_k     <= '0;
            r_state <= CHECK;
          end else begin
            r_state <= IDLE;
          end
        end
        CHECK: begin
          if (M) begin
            r_state <= SHIFT;
          end else if (w_last) begin
            r_state <= DONE;
          end else begin
            r_k     <= r_k + KW'(1);
            r_state <= CHECK;
          end
        end
        SHIFT: begin
          if (w_last) begin
            r_state <= DONE;
          end else begin
            r_k     <= r_k + KW'(1);
            r_state <= CHECK;
          end
        end
        DONE: begin
          if (!St) begin
            r_k     <= '0;
            r_state <= IDLE;
          end else begin
            r_state <= DONE;
          end
        end
        default: begin
          r_k     <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Strobe decode; everything is held low while reset is asserted, even with St high.
  always_comb begin
    Load = 1'b0;
    Ad   = 1'b0;
    Sh   = 1'b0;
    Busy = 1'b0;
    Done = 1'b0;
    if (Rst_n) begin
      case (r_state)
        IDLE: begin
          if (St) begin
            Load = 1'b1;
            Busy = 1'b1;
          end else begin
            Busy = 1'b0;
          end
        end
        CHECK: begin
          Busy = 1'b1;
          if (M) begin
            Ad = 1'b1;
          end else begin
            Sh = 1'b1;
          end
        end
        SHIFT: begin
          Busy = 1'b1;
          Sh   = 1'b1;
        end
        DONE: begin
          Done = 1'b1;
        end
        default: begin
          Busy = 1'b0;
        end
      endcase
    end else begin
      Busy = 1'b0;
    end
  end

endmodule

// File: tb/tb_controle_mult.sv
// tb_controle_mult: scoreboard bench for controle_mult with N=4. A small
// accumulator model feeds M from the DUT strobes; the expected per-cycle
// strobe vector {Load,Ad,Sh,Busy,Done} is queued as stimulus is planned.
module tb_controle_mult;

  logic Clk = 1'b0;
  logic Rst_n;
  logic St;
  logic M;
  logic Load, Ad, Sh, Busy, Done;

  logic [3:0] mult_r = 4'b0000;
  logic [3:0] acc_r  = 4'b0000;
  logic [4:0] exp_q[$];

  int n_checks = 0;
  int n_fails  = 0;

  controle_mult #(.N(4)) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .St   (St),
    .M    (M),
    .Load (Load),
    .Ad   (Ad),
    .Sh   (Sh),
    .Busy (Busy),
    .Done (Done)
  );

  always #5 Clk = ~Clk;

  // Accumulator model: load the multiplier, shift it right on Sh.
  always @(posedge Clk) begin
    if (Load) acc_r <= mult_r;
    else if (Sh) acc_r <= acc_r >> 1;
  end

  assign M = acc_r[0];

  wire logic [4:0] obs = {Load, Ad, Sh, Busy, Done};

  task automatic check_val(input string tag, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %b expected %b", tag, act, exp);
    end
  endtask

  // One clock cycle: drive St after the edge, compare at the falling edge.
  task automatic cycle_check(input string tag, input logic st_v);
    logic [4:0] e;
    logic ok;
    @(posedge Clk);
    #1 St = st_v;
    @(negedge Clk);
    if (exp_q.size() == 0) begin
      check_val({tag, "_empty_q"}, 5'd1, 5'd0);
    end else begin
      e = exp_q.pop_front();
      check_val(tag, obs, e);
    end
    ok = (int'(Load) + int'(Ad) + int'(Sh)) <= 1;
    check_val({tag, "_onehot"}, {4'b0000, ok}, 5'b00001);
  endtask

  // Full multiplication: hold = Done cycles with St high, tail = idle cycles afterwards.
  task automatic run_mult(input string tag, input logic [3:0] mult, input int hold, input int tail);
    int n_on;
    int total;
    mult_r = mult;
    total  = 0;
    exp_q.push_back(5'b10010); total++;
    for (int i = 0; i < 4; i++) begin
      if (mult[i]) begin
        exp_q.push_back(5'b01010); total++;
      end
      exp_q.push_back(5'b00110); total++;
    end
    for (int i = 0; i < hold; i++) begin
      exp_q.push_back(5'b00001); total++;
    end
    n_on = total;
    exp_q.push_back(5'b00001); total++;
    for (int i = 0; i < tail; i++) begin
      exp_q.push_back(5'b00000); total++;
    end
    for (int i = 0; i < total; i++) begin
      cycle_check(tag, i < n_on);
    end
  endtask

  initial begin
    Rst_n = 1'b0;
    St    = 1'b1;
    #1;
    check_val("rst_async", obs, 5'b00000);
    repeat (2) begin
      @(negedge Clk);
      check_val("rst_hold", obs, 5'b00000);
    end
    St = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    exp_q.push_back(5'b00000);
    exp_q.push_back(5'b00000);
    cycle_check("idle_after_rst", 1'b0);
    cycle_check("idle_after_rst", 1'b0);

    run_mult("m1011", 4'b1011, 1, 1);
    run_mult("m0000", 4'b0000, 1, 1);
    run_mult("m1111", 4'b1111, 1, 1);
    // St held through DONE, then a one-cycle release and an immediate restart.
    run_mult("hold5", 4'b0101, 5, 0);
    run_mult("b2b",   4'b0010, 1, 1);

    // Reset during the SHIFT of the second iteration.
    mult_r = 4'b1111;
    exp_q.push_back(5'b10010);
    exp_q.push_back(5'b01010);
    exp_q.push_back(5'b00110);
    exp_q.push_back(5'b01010);
    for (int i = 0; i < 4; i++) cycle_check("rstmid_pre", 1'b1);
    @(posedge Clk);
    #1;
    check_val("rstmid_shift", obs, 5'b00110);
    Rst_n = 1'b0;
    #1;
    check_val("rstmid_async", obs, 5'b00000);
    @(negedge Clk);
    check_val("rstmid_hold", obs, 5'b00000);
    St = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    run_mult("after_rst", 4'b1101, 1, 1);
    run_mult("m1001",     4'b1001, 2, 2);

    if (exp_q.size() != 0) check_val("q_leftover", 5'd1, 5'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
